// File: rtl/array_pmr.sv
// Flop-based register array with NUM_RD read ports, one lane-masked write port,
// per-entry valid bits and a sequential invalidate sweep.
module array_pmr #(
  parameter int S_INDEX = 3,
  parameter int WIDTH   = 1,
  parameter int NUM_RD  = 2,
  parameter int GRAN    = WIDTH,
  parameter int REG_OUT = 0,
  parameter int BYPASS  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_RD-1:0]           read,
  input  logic [NUM_RD*S_INDEX-1:0]   rindex,
  output logic [NUM_RD*WIDTH-1:0]     dataout,
  output logic [NUM_RD-1:0]           valid_out,
  input  logic                        load,
  input  logic [S_INDEX-1:0]          windex,
  input  logic [WIDTH/GRAN-1:0]       wmask,
  input  logic [WIDTH-1:0]            datain,
  input  logic                        flush,
  output logic                        flush_busy,
  output logic                        flush_done
);

  localparam int NUM_SETS = 1 << S_INDEX;
  localparam int NLANE    = WIDTH / GRAN;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                             state_q;
  logic [S_INDEX-1:0]                 ptr_q;
  logic                               flush_busy_q;
  logic                               flush_done_q;

  logic [NUM_SETS-1:0][WIDTH-1:0]     data_q, data_d;
  logic [NUM_SETS-1:0]                valid_q, valid_d;
  logic [WIDTH-1:0]                   wbits;
  logic [WIDTH-1:0]                   wmerged;
  logic [NUM_RD*WIDTH-1:0]            rd_data;
  logic [NUM_RD-1:0]                  rd_valid;

  // The merged write word feeds both the array update and the bypass path.
  always_comb begin
    wbits = '0;
    for (int k = 0; k < NLANE; k++) begin
      wbits[k*GRAN +: GRAN] = {GRAN{wmask[k]}};
    end
    wmerged = (data_q[windex] & ~wbits) | (datain & wbits);
  end

  // The sweep clears first so a same-cycle write to the swept set wins.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (state_q == ST_SWEEP) begin
      valid_d[ptr_q] = 1'b0;
    end
    if (load) begin
      data_d[windex]  = wmerged;
      valid_d[windex] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      flush_busy_q <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          flush_done_q <= 1'b0;
          if (flush) begin
            state_q      <= ST_SWEEP;
            ptr_q        <= '0;
            flush_busy_q <= 1'b1;
          end
        end
        ST_SWEEP: begin
          ptr_q <= ptr_q + S_INDEX'(1);
          if (ptr_q == S_INDEX'(NUM_SETS - 1)) begin
            state_q      <= ST_DONE;
            flush_busy_q <= 1'b0;
            flush_done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q      <= ST_IDLE;
          flush_done_q <= 1'b0;
        end
        default: begin
          state_q      <= ST_IDLE;
          flush_busy_q <= 1'b0;
          flush_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign flush_busy = flush_busy_q;
  assign flush_done = flush_done_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [S_INDEX-1:0] ridx;
    logic               hit;
    assign ridx = rindex[i*S_INDEX +: S_INDEX];
    assign hit  = (BYPASS != 0) && load && (ridx == windex);
    assign rd_data[i*WIDTH +: WIDTH] = hit ? wmerged : data_q[ridx];
    assign rd_valid[i]               = hit || valid_q[ridx];
  end

  if (REG_OUT != 0) begin : g_reg
    logic [NUM_RD*WIDTH-1:0] dout_q, dout_d;
    logic [NUM_RD-1:0]       vout_q, vout_d;

    always_comb begin
      dout_d = dout_q;
      vout_d = vout_q;
      for (int i = 0; i < NUM_RD; i++) begin
        if (read[i]) begin
          dout_d[i*WIDTH +: WIDTH] = rd_data[i*WIDTH +: WIDTH];
          vout_d[i]                = rd_valid[i];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
        vout_q <= '0;
      end else begin
        dout_q <= dout_d;
        vout_q <= vout_d;
      end
    end

    assign dataout   = dout_q;
    assign valid_out = vout_q;
  end else begin : g_comb
    // Read enables only matter for the registered variant.
    logic unused_read;
    assign unused_read = ^read;
    assign dataout     = rd_data;
    assign valid_out   = rd_valid;
  end

endmodule

// File: tb/tb_array_pmr.sv
// Bench for array_pmr: a combinational-read and a registered-read instance share
// one stimulus stream and are checked against a behavioural model of the array.
`timescale 1ns/1ps
module tb_array_pmr;

  logic        clk;
  logic        rst;
  logic [1:0]  read;
  logic [5:0]  rindex;
  logic        load;
  logic [2:0]  windex;
  logic [3:0]  wmask;
  logic [31:0] datain;
  logic        flush;

  logic [63:0] dout0, dout1;
  logic [1:0]  vout0, vout1;
  logic        busy0, busy1, done0, done1;

  int n_vec = 0;
  int n_err = 0;

  // Model state: array contents, valid bits, registered port copies and the
  // position in the flush timeline (0 idle, 1..8 sweeping set phase-1, 9 done).
  logic [31:0] m_mem[8];
  logic [7:0]  m_vld;
  logic [31:0] m_reg[2];
  logic [1:0]  m_regv;
  int          m_phase;

  typedef struct {
    logic        load;
    logic [2:0]  windex;
    logic [3:0]  wmask;
    logic [31:0] datain;
    logic [2:0]  ri0;
    logic [2:0]  ri1;
    logic [31:0] e_d0;
    logic        e_v0;
    logic [31:0] e_d1;
    logic        e_v1;
  } vec_t;

  vec_t tbl[8];

  array_pmr #(.S_INDEX(3), .WIDTH(32), .NUM_RD(2), .GRAN(8), .REG_OUT(0), .BYPASS(1)) dut_comb (
    .clk(clk), .rst(rst), .read(read), .rindex(rindex), .dataout(dout0), .valid_out(vout0),
    .load(load), .windex(windex), .wmask(wmask), .datain(datain), .flush(flush),
    .flush_busy(busy0), .flush_done(done0)
  );

  array_pmr #(.S_INDEX(3), .WIDTH(32), .NUM_RD(2), .GRAN(8), .REG_OUT(1), .BYPASS(1)) dut_reg (
    .clk(clk), .rst(rst), .read(read), .rindex(rindex), .dataout(dout1), .valid_out(vout1),
    .load(load), .windex(windex), .wmask(wmask), .datain(datain), .flush(flush),
    .flush_busy(busy1), .flush_done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (m[k]) r[k*8 +: 8] = din[k*8 +: 8];
    return r;
  endfunction

  task automatic drive(input logic ld, input logic [2:0] wi, input logic [3:0] wm,
                       input logic [31:0] di, input logic [2:0] r0, input logic [2:0] r1,
                       input logic [1:0] rd, input logic fl);
    load = ld; windex = wi; wmask = wm; datain = di;
    rindex = {r1, r0}; read = rd; flush = fl;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++) m_mem[s] = '0;
    m_vld   = '0;
    m_reg[0] = '0; m_reg[1] = '0;
    m_regv  = '0;
    m_phase = 0;
  endtask

  // Check all outputs against the model, clock once, then advance the model.
  task automatic cycle();
    logic [31:0] md[2];
    logic        mv[2];
    logic [2:0]  idx;
    #1;
    for (int p = 0; p < 2; p++) begin
      idx = (p == 0) ? rindex[2:0] : rindex[5:3];
      if (load && idx == windex) begin
        md[p] = merge(m_mem[idx], datain, wmask);
        mv[p] = 1'b1;
      end else begin
        md[p] = m_mem[idx];
        mv[p] = m_vld[idx];
      end
    end
    chk("comb_data0", dout0[31:0], md[0]);
    chk("comb_data1", dout0[63:32], md[1]);
    chk("comb_valid0", {31'd0, vout0[0]}, {31'd0, mv[0]});
    chk("comb_valid1", {31'd0, vout0[1]}, {31'd0, mv[1]});
    chk("reg_data0", dout1[31:0], m_reg[0]);
    chk("reg_data1", dout1[63:32], m_reg[1]);
    chk("reg_valid", {30'd0, vout1}, {30'd0, m_regv});
    chk("flush_busy", {30'd0, busy1, busy0}, (m_phase >= 1 && m_phase <= 8) ? 32'd3 : 32'd0);
    chk("flush_done", {30'd0, done1, done0}, (m_phase == 9) ? 32'd3 : 32'd0);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (read[p]) begin
          m_reg[p]  = md[p];
          m_regv[p] = mv[p];
        end
      end
      if (m_phase >= 1 && m_phase <= 8) m_vld[m_phase-1] = 1'b0;
      if (load) begin
        m_mem[windex] = merge(m_mem[windex], datain, wmask);
        m_vld[windex] = 1'b1;
      end
      if (m_phase == 0) m_phase = flush ? 1 : 0;
      else if (m_phase == 9) m_phase = 0;
      else m_phase = m_phase + 1;
    end
    @(negedge clk);
  endtask

  initial begin
    int busy_cnt;
    int done_at;

    tbl[0] = '{1'b0, 3'd0, 4'h0, 32'h0,        3'd5, 3'd0, 32'h0,        1'b0, 32'h0,        1'b0};
    tbl[1] = '{1'b1, 3'd5, 4'hF, 32'hAABBCCDD, 3'd5, 3'd5, 32'hAABBCCDD, 1'b1, 32'hAABBCCDD, 1'b1};
    tbl[2] = '{1'b1, 3'd5, 4'h5, 32'h11223344, 3'd5, 3'd4, 32'hAA22CC44, 1'b1, 32'h0,        1'b0};
    tbl[3] = '{1'b0, 3'd0, 4'h0, 32'h0,        3'd5, 3'd5, 32'hAA22CC44, 1'b1, 32'hAA22CC44, 1'b1};
    tbl[4] = '{1'b1, 3'd3, 4'hF, 32'h5,        3'd3, 3'd3, 32'h5,        1'b1, 32'h5,        1'b1};
    tbl[5] = '{1'b1, 3'd3, 4'h0, 32'hFFFFFFFF, 3'd3, 3'd5, 32'h5,        1'b1, 32'hAA22CC44, 1'b1};
    tbl[6] = '{1'b1, 3'd2, 4'h8, 32'h12345678, 3'd2, 3'd3, 32'h12000000, 1'b1, 32'h5,        1'b1};
    tbl[7] = '{1'b0, 3'd0, 4'h0, 32'h0,        3'd2, 3'd7, 32'h12000000, 1'b1, 32'h0,        1'b0};

    drive(1'b0, 3'd0, 4'h0, 32'h0, 3'd0, 3'd0, 2'b00, 1'b0);
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state visible on every set and port.
    for (int s = 0; s < 8; s++) begin
      drive(1'b0, 3'd0, 4'h0, 32'h0, 3'(s), 3'(7 - s), 2'b11, 1'b0);
      #1;
      chk("rst_data", dout0[31:0] | dout0[63:32], 32'h0);
      chk("rst_valid", {30'd0, vout0}, 32'h0);
      cycle();
    end

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].load, tbl[i].windex, tbl[i].wmask, tbl[i].datain, tbl[i].ri0, tbl[i].ri1,
            2'b11, 1'b0);
      #1;
      chk("tbl_data0", dout0[31:0], tbl[i].e_d0);
      chk("tbl_valid0", {31'd0, vout0[0]}, {31'd0, tbl[i].e_v0});
      chk("tbl_data1", dout0[63:32], tbl[i].e_d1);
      chk("tbl_valid1", {31'd0, vout0[1]}, {31'd0, tbl[i].e_v1});
      cycle();
    end

    // Registered read: one cycle of latency, disabled port holds.
    drive(1'b0, 3'd0, 4'h0, 32'h0, 3'd5, 3'd7, 2'b01, 1'b0);
    #1;
    chk("regout_before", dout1[31:0], 32'h12000000);
    cycle();
    drive(1'b0, 3'd0, 4'h0, 32'h0, 3'd5, 3'd5, 2'b00, 1'b0);
    #1;
    chk("regout_after", dout1[31:0], 32'hAA22CC44);
    chk("regout_hold", dout1[63:32], 32'h0);
    cycle();

    // Full sweep with writes landing ahead of, behind and on the pointer.
    for (int s = 0; s < 8; s++) begin
      drive(1'b1, 3'(s), 4'hF, $urandom, 3'(s), 3'd0, 2'b11, 1'b0);
      cycle();
    end
    drive(1'b0, 3'd0, 4'h0, 32'h0, 3'd0, 3'd1, 2'b11, 1'b1);
    cycle();
    busy_cnt = 0;
    done_at  = -1;
    for (int c = 1; c <= 10; c++) begin
      drive(1'b0, 3'd0, 4'h0, 32'h0, 3'(c % 8), 3'd6, 2'b11, (c == 2 || c == 9) ? 1'b1 : 1'b0);
      if (c == 3) begin load = 1'b1; windex = 3'd6; wmask = 4'hF; datain = 32'h66666666; end
      if (c == 4) begin load = 1'b1; windex = 3'd1; wmask = 4'hF; datain = 32'h11111111; end
      if (c == 5) begin load = 1'b1; windex = 3'd4; wmask = 4'h3; datain = 32'h44444444; end
      #1;
      busy_cnt += int'(busy0);
      if (done0 && done_at < 0) done_at = c;
      cycle();
    end
    chk("sweep_busy_cycles", 32'(busy_cnt), 32'd8);
    chk("sweep_done_offset", 32'(done_at), 32'd9);
    for (int s = 0; s < 8; s++) begin
      drive(1'b0, 3'd0, 4'h0, 32'h0, 3'(s), 3'(s), 2'b00, 1'b0);
      #1;
      chk("sweep_valid", {31'd0, vout0[0]}, (s == 1 || s == 4) ? 32'd1 : 32'd0);
      cycle();
    end

    // Reset in the middle of a sweep.
    drive(1'b0, 3'd0, 4'h0, 32'h0, 3'd0, 3'd0, 2'b00, 1'b1);
    cycle();
    for (int c = 1; c <= 4; c++) begin
      drive(1'b0, 3'd0, 4'h0, 32'h0, 3'd0, 3'd0, 2'b00, 1'b0);
      cycle();
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("abort_busy", {30'd0, busy1, busy0}, 32'h0);
    for (int s = 0; s < 8; s++) begin
      drive(1'b0, 3'd0, 4'h0, 32'h0, 3'(s), 3'(s), 2'b11, 1'b0);
      #1;
      chk("abort_done", {30'd0, done1, done0}, 32'h0);
      chk("abort_entry", dout0[31:0], 32'h0);
      chk("abort_valid", {30'd0, vout0}, 32'h0);
      cycle();
    end

    // Random traffic with occasional flushes and resets.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            $urandom, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
      rst = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
